sr_load_ctrl: RTL and testbench
===============================

# sr_load_ctrl

Serial loader and arbiter for the i4003 shift-register expander. Two requesters each present a 10-bit parallel word; the block grants them round-robin and serialises the granted word onto the i4003 `cp`/`data`/`e` lines with programmable bit timing. It then re-enables the parallel outputs and acknowledges the requester. It sits between ROM-port-driven control logic and the i4003 in the MCS-4 system top level, replacing direct bit-banging of `rom_io[63:61]`.

## Interface
- `WIDTH`, default 10: bits per load; equals the i4003 parallel width.
- `DIV`, default 2, range 1–255: `cp1` cycles per half-period of `sr_cp`.
- `cp1` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 2: per-requester load request; level, held until `ack`.
- `word0` in WIDTH: requester 0 data; sampled at grant.
- `word1` in WIDTH: requester 1 data; sampled at grant.
- `ack` out 2: one-cycle completion pulse, one-hot to the granted requester.
- `busy` out 1: high from the grant cycle through the ack cycle inclusive.
- `sr_cp` out 1: i4003 shift clock; the i4003 shifts on its rising edge.
- `sr_data` out 1: i4003 serial data.
- `sr_e` out 1: i4003 parallel-output enable.
- `sr_sout` in 1: i4003 serial out. Present only with `SR_READBACK_EN`.
- `rd_data` out WIDTH: previous i4003 contents. Present only with `SR_READBACK_EN`.
- `rd_valid` out 1: one-cycle pulse coincident with `ack`. Present only with `SR_READBACK_EN`.

## Operation
- Reset values: `ack`=0, `busy`=0, `sr_cp`=0, `sr_data`=0, `sr_e`=0, `rd_data`=0, `rd_valid`=0. Round-robin pointer favours requester 0.
- **IDLE**
  - If any `req` bit is high, grant it.
  - If both are high, grant the pointer's requester.
  - On grant: latch that requester's word into the shift register, clear the bit counter, set `busy`, drive `sr_e`=0, go to LO.
  - The pointer flips to the other requester after every grant.
- **LO**
  - Hold `sr_cp`=0 for DIV cycles.
  - Drive `sr_data` = current MSB of the latched word.
  - Go to HI.
- **HI**
  - Hold `sr_cp`=1 for DIV cycles; `sr_data` stays stable throughout.
  - On exit: shift the latched word left by one and increment the counter.
  - If the counter reaches WIDTH, go to DONE; otherwise go to LO.
- **DONE**
  - Lasts one cycle: `sr_cp`=0, `sr_e`=1, `ack[grant]`=1, `busy` still 1.
  - Then go to IDLE.
- Bit order is MSB first, so `wordN[WIDTH-1]` lands on i4003 `p_out[WIDTH-1]`.
- After the first completed load, `sr_e` stays 1 until the next grant.
- A `req` that drops before grant is ignored.
- A `req` that drops mid-transfer does not abort the transfer; `ack` still pulses.
- A requester re-asserting in the cycle after its ack is served only after the other requester, if that one is pending.
- `reset` mid-transfer: every output returns to its reset value at the next edge and no ack is issued. i4003 contents are then undefined; the next load rewrites all WIDTH bits.

## Timing
- Grant happens at the first edge where `req` is sampled high in IDLE (cycle 0).
- `ack` rises at cycle 2·DIV·WIDTH + 1. For DIV=2, WIDTH=10 that is cycle 41.
- Back-to-back throughput: one load per 2·DIV·WIDTH + 2 cycles; IDLE takes one cycle between loads.
- `sr_data` changes only on LO entry, giving DIV cycles of setup and DIV cycles of hold around each `sr_cp` rise.
- Counter width is clog2(WIDTH+1). The DIV counter is 8-bit and reloads on every phase change.

## Configuration
- `SR_READBACK_EN` defined:
  - In the last cycle of each LO phase, `sr_sout` is shifted LSB-in into a WIDTH-bit capture register.
  - At DONE, `rd_data` ← capture register and `rd_valid` pulses.
  - `rd_data` holds until the next DONE.
- `SR_READBACK_EN` undefined: the `sr_sout`, `rd_data` and `rd_valid` ports and the capture logic are absent.

## Structure
- Shared package `mcs4_pkg` holds:
  - `sr_state_t` enum: IDLE, LO, HI, DONE.
  - Constants `SR_WIDTH=10` and `SR_DIV_DEFAULT=2`.
- One sub-module, `sr_rr_arb`: 2-way round-robin arbiter.
  - Inputs: `req`, `advance`.
  - Output: one-hot `gnt`.
  - Pointer state lives inside it.

## Test plan
- Single load: `req`=01, `word0`=10'h2A5 → `ack[0]` at cycle 41. The bench model of the i4003 shows 10'h2A5 and `sr_e`=1 at cycle 41.
- Contention: `req`=11 from reset → requester 0 served first with `ack`=01 at cycle 41. Requester 1 is granted at cycle 42 and acked at cycle 83 with `ack`=10.
- Fairness: both requesters held high for 4 loads → ack order 0,1,0,1. Nothing is lost, and `busy` is low for exactly one cycle between loads.
- DIV=1, WIDTH=10, `word1`=10'h3FF → `ack` at cycle 21. Every `sr_cp` high and low phase is exactly 1 cycle.
- Reset at cycle 15 of a load → the next cycle shows `sr_cp`=0, `sr_e`=0, `busy`=0 and no ack. A following load of 10'h155 completes correctly.
- Readback (`SR_READBACK_EN`): load 10'h2A5, then load 10'h0F0 → on the second ack, `rd_valid`=1 and `rd_data`=10'h2A5.

Source files
------------

// File: rtl/mcs4_pkg.sv
// mcs4_pkg: shared types and constants for the i4003 serial loader
package mcs4_pkg;
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} sr_state_t;
   localparam int SR_WIDTH       = 10;
   localparam int SR_DIV_DEFAULT = 2;
endpackage

// File: rtl/sr_rr_arb.sv
// sr_rr_arb: 2-way round-robin arbiter, pointer moves to the loser after each grant
import mcs4_pkg::*;
module sr_rr_arb (
   input  logic       cp1,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic r_ptr;
   assign gnt = {req[1] & (r_ptr | ~req[0]), req[0] & (~r_ptr | ~req[1])};
   // pointer favours requester 0 after reset and flips to the other side on each grant
   always_ff @(posedge cp1) begin
      if (reset) r_ptr <= 1'b0;
      else if (advance) r_ptr <= gnt[0];
   end
endmodule

// File: rtl/sr_load_ctrl.sv
// sr_load_ctrl: arbitrated serial loader for the i4003; SR_READBACK_EN adds sout capture
import mcs4_pkg::*;
module sr_load_ctrl #(
   parameter int WIDTH = SR_WIDTH,
   parameter int DIV   = SR_DIV_DEFAULT
) (
   input  logic             cp1,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] word0,
   input  logic [WIDTH-1:0] word1,
   output logic [1:0]       ack,
   output logic             busy,
   output logic             sr_cp,
   output logic             sr_data,
   output logic             sr_e
`ifdef SR_READBACK_EN
   ,
   input  logic             sr_sout,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
   sr_state_t        r_state, w_next;
   logic [7:0]       r_div;
   logic [CW-1:0]    r_bit;
   logic [WIDTH-1:0] r_sh;
   logic [1:0]       r_gnt, w_gnt;
   logic             r_e, w_grant, w_tick, w_last;
   sr_rr_arb u_arb (.cp1(cp1), .reset(reset), .req(req), .advance(w_grant), .gnt(w_gnt));
   assign w_grant = (r_state == IDLE) && (|req);
   assign w_tick  = r_div == 8'd0;
   assign w_last  = r_bit == CW'(WIDTH - 1);
   assign ack     = (r_state == DONE) ? r_gnt : 2'b00;
   assign busy    = r_state != IDLE;
   assign sr_cp   = r_state == HI;
   assign sr_data = r_sh[WIDTH-1];
   assign sr_e    = r_e;
   // phase sequencing: IDLE -> (LO -> HI) x WIDTH -> DONE -> IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (|req) ? LO : IDLE;
         LO:      w_next = w_tick ? HI : LO;
         HI:      w_next = w_tick ? (w_last ? DONE : LO) : HI;
         default: w_next = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge cp1) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   // word latch, MSB-first shifting, phase and bit counters, output enable
   always_ff @(posedge cp1) begin
      if (reset) begin
         r_div <= 8'd0;
         r_bit <= '0;
         r_sh  <= '0;
         r_gnt <= 2'b00;
         r_e   <= 1'b0;
      end else if (w_grant) begin
         r_sh  <= w_gnt[1] ? word1 : word0;
         r_gnt <= w_gnt;
         r_bit <= '0;
         r_div <= DIV_M1;
         r_e   <= 1'b0;
      end else if (r_state == LO || r_state == HI) begin
         r_div <= w_tick ? DIV_M1 : r_div - 8'd1;
         if (r_state == HI && w_tick) begin
            r_sh  <= r_sh << 1;
            r_bit <= r_bit + CW'(1);
            if (w_last) r_e <= 1'b1;
         end
      end
   end
`ifdef SR_READBACK_EN
   logic [WIDTH-1:0] r_cap, r_rd;
   assign rd_data  = r_rd;
   assign rd_valid = r_state == DONE;
   // sample sout just before each cp rise; publish the full word entering DONE
   always_ff @(posedge cp1) begin
      if (reset) begin
         r_cap <= '0;
         r_rd  <= '0;
      end else begin
         if (r_state == LO && w_tick) r_cap <= {r_cap[WIDTH-2:0], sr_sout};
         if (r_state == HI && w_tick && w_last) r_rd <= r_cap;
      end
   end
`endif
endmodule

// File: tb/tb_sr_load_ctrl.sv
// tb_sr_load_ctrl: directed and randomized checks of sr_load_ctrl against an i4003 model
module tb_sr_load_ctrl;
   logic       cp1 = 1'b0, reset = 1'b1;
   logic [1:0] req = 2'b00, req_b = 2'b00;
   logic [9:0] word0 = '0, word1 = '0;
   logic [1:0] ack, b_ack;
   logic       busy, sr_cp, sr_data, sr_e, b_busy, b_cp, b_data, b_e;
   logic [9:0] m_sr = '0, m1_sr = '0;
`ifdef SR_READBACK_EN
   logic [9:0] rd_data, b_rd_data;
   logic       rd_valid, b_rd_valid;
`endif
   int n_chk = 0, n_fail = 0;
   always #5 cp1 = ~cp1;
   sr_load_ctrl #(.WIDTH(10), .DIV(2)) dut (
      .cp1(cp1), .reset(reset), .req(req), .word0(word0), .word1(word1),
      .ack(ack), .busy(busy), .sr_cp(sr_cp), .sr_data(sr_data), .sr_e(sr_e)
`ifdef SR_READBACK_EN
      , .sr_sout(m_sr[9]), .rd_data(rd_data), .rd_valid(rd_valid)
`endif
   );
   sr_load_ctrl #(.WIDTH(10), .DIV(1)) dut1 (
      .cp1(cp1), .reset(reset), .req(req_b), .word0(word0), .word1(word1),
      .ack(b_ack), .busy(b_busy), .sr_cp(b_cp), .sr_data(b_data), .sr_e(b_e)
`ifdef SR_READBACK_EN
      , .sr_sout(m1_sr[9]), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
`endif
   );
   // i4003 shift registers: shift in data on each sr_cp rise
   always @(posedge sr_cp) m_sr <= {m_sr[8:0], sr_data};
   always @(posedge b_cp) m1_sr <= {m1_sr[8:0], b_data};
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge cp1);
   endtask
   task automatic wait_ack(output int n, output int idle);
      n = 0;
      idle = 0;
      do begin
         @(negedge cp1);
         n++;
         if (!busy) idle++;
      end while (ack == 2'b00 && n < 200);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      req = 2'b00;
      req_b = 2'b00;
      cyc(3);
      reset = 1'b0;
   endtask
   initial begin
      int n, idle, ptr, bad, r;
      logic [9:0] w [2];
      localparam int LAT = 2 * 2 * 10 + 1;
      cyc(1);
      do_reset();
      chk("rst ack", ack, 0);
      chk("rst busy", busy, 0);
      chk("rst sr_cp", sr_cp, 0);
      chk("rst sr_data", sr_data, 0);
      chk("rst sr_e", sr_e, 0);
      chk("rst b_busy", b_busy, 0);
`ifdef SR_READBACK_EN
      chk("rst rd_data", rd_data, 0);
      chk("rst rd_valid", rd_valid, 0);
`endif
      word0 = 10'h2A5;
      word1 = 10'($urandom_range(0, 1023));
      req = 2'b01;
      cyc(1);
      chk("single busy c1", busy, 1);
      chk("single sr_e c1", sr_e, 0);
      chk("single msb c1", sr_data, 1);
      cyc(LAT - 2);
      chk("single no early ack", ack, 0);
      cyc(1);
      chk("single ack", ack, 2'b01);
      chk("single busy at ack", busy, 1);
      chk("single sr_e at ack", sr_e, 1);
      chk("single i4003", m_sr, 10'h2A5);
      req = 2'b00;
      cyc(1);
      chk("single idle busy", busy, 0);
      chk("single idle ack", ack, 0);
      chk("single sr_e holds", sr_e, 1);
      do_reset();
      w[0] = 10'($urandom_range(0, 1023));
      w[1] = 10'($urandom_range(0, 1023));
      word0 = w[0];
      word1 = w[1];
      req = 2'b11;
      wait_ack(n, idle);
      chk("cont first cycle", n, LAT);
      chk("cont first ack", ack, 2'b01);
      chk("cont first word", m_sr, w[0]);
      req = 2'b10;
      wait_ack(n, idle);
      chk("cont second cycles", n, LAT + 1);
      chk("cont second ack", ack, 2'b10);
      chk("cont second word", m_sr, w[1]);
      req = 2'b00;
      do_reset();
      ptr = 0;
      w[0] = 10'($urandom_range(0, 1023));
      w[1] = 10'($urandom_range(0, 1023));
      word0 = w[0];
      word1 = w[1];
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_ack(n, idle);
         r = ptr;
         ptr ^= 1;
         chk($sformatf("fair%0d ack", k), ack, 32'(1 << r));
         chk($sformatf("fair%0d word", k), m_sr, w[r]);
         chk($sformatf("fair%0d cycles", k), n, (k == 0) ? LAT : LAT + 1);
         chk($sformatf("fair%0d idle", k), idle, (k == 0) ? 0 : 1);
         w[r] = 10'($urandom_range(0, 1023));
         word0 = w[0];
         word1 = w[1];
      end
      req = 2'b00;
      cyc(2);
      word1 = 10'h3FF;
      req_b = 2'b10;
      bad = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         if (b_cp !== ((k % 2) == 0)) bad++;
         if (b_ack !== 2'b00) bad++;
      end
      chk("div1 phase errors", bad, 0);
      cyc(1);
      chk("div1 ack", b_ack, 2'b10);
      chk("div1 i4003", m1_sr, 10'h3FF);
      req_b = 2'b00;
      cyc(2);
      do_reset();
      word0 = 10'($urandom_range(0, 1023));
      req = 2'b01;
      cyc(15);
      reset = 1'b1;
      req = 2'b00;
      cyc(1);
      chk("midrst sr_cp", sr_cp, 0);
      chk("midrst sr_e", sr_e, 0);
      chk("midrst busy", busy, 0);
      chk("midrst ack", ack, 0);
      reset = 1'b0;
      word0 = 10'h155;
      req = 2'b01;
      wait_ack(n, idle);
      chk("post rst cycles", n, LAT);
      chk("post rst ack", ack, 2'b01);
      chk("post rst i4003", m_sr, 10'h155);
      req = 2'b00;
`ifdef SR_READBACK_EN
      cyc(1);
      word0 = 10'h2A5;
      req = 2'b01;
      wait_ack(n, idle);
      chk("rb1 rd_valid", rd_valid, 1);
      chk("rb1 rd_data", rd_data, 10'h155);
      req = 2'b00;
      cyc(1);
      chk("rb1 rd_valid drop", rd_valid, 0);
      word0 = 10'h0F0;
      req = 2'b01;
      wait_ack(n, idle);
      chk("rb2 rd_valid", rd_valid, 1);
      chk("rb2 rd_data", rd_data, 10'h2A5);
      req = 2'b00;
      cyc(1);
      chk("rb2 rd_data holds", rd_data, 10'h2A5);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
